// File: rtl/dataram_arbiter_pkg.sv
// Shared types for the data RAM arbiter: pending-read owner and request bundle.
package dataram_arbiter_pkg;

    localparam int DR_ADDRWIDTH = 12;
    localparam int DR_DATAWIDTH = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic                    we;
        logic [DR_ADDRWIDTH-1:0] addr;
        logic [DR_DATAWIDTH-1:0] wdata;
    } dr_req_t;

endpackage

// File: rtl/dataram_arbiter_starve_counter.sv
// Counts consecutive denied DMA cycles; once MAXWAIT is reached the DMA port is forced a grant.
module arb_starve_counter #(
    parameter int MAXWAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_grant,
    output logic force_dma
);

    localparam int CW = $clog2(MAXWAIT + 1);

    logic [CW-1:0] r_waitcnt;
    logic          w_at_max;

    assign w_at_max  = (r_waitcnt == CW'(MAXWAIT));
    assign force_dma = dma_req && w_at_max;

    // Saturates at MAXWAIT so a long core burst cannot wrap the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_waitcnt <= '0;
        end else if (!dma_req || dma_grant) begin
            r_waitcnt <= '0;
        end else if (!w_at_max) begin
            r_waitcnt <= r_waitcnt + 1'b1;
        end
    end

endmodule

// File: rtl/dataram_arbiter.sv
// Single-port data RAM arbiter: core has priority, DMA is guaranteed a slot, read data
// is steered back to whichever port issued it one cycle earlier.
module dataram_arbiter
    import dataram_arbiter_pkg::*;
#(
    parameter int ADDRWIDTH = DR_ADDRWIDTH,
    parameter int DATAWIDTH = DR_DATAWIDTH,
    parameter int RAMDEPTH  = 1024,
    parameter int MAXWAIT   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [ADDRWIDTH-1:0] core_addr,
    input  logic [DATAWIDTH-1:0] core_wdata,
    output logic                 core_ready,
    output logic                 core_rvalid,
    output logic [DATAWIDTH-1:0] core_rdata,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [ADDRWIDTH-1:0] dma_addr,
    input  logic [DATAWIDTH-1:0] dma_wdata,
    output logic                 dma_ready,
    output logic                 dma_rvalid,
    output logic [DATAWIDTH-1:0] dma_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    input  logic [DATAWIDTH-1:0] ram_rdata,
    output logic                 addr_err
);

    logic    w_force_dma;
    logic    w_dma_win;
    logic    w_core_win;
    logic    w_xfer;
    logic    w_oor;
    dr_req_t w_sel;
    owner_t  r_pend_owner;
    logic    r_pend_oor;
    logic    r_addr_err;

    arb_starve_counter #(.MAXWAIT(MAXWAIT)) u_starve (
        .clock     (clock),
        .reset     (reset),
        .dma_req   (dma_req),
        .dma_grant (dma_ready),
        .force_dma (w_force_dma)
    );

    assign w_dma_win  = dma_req && (!core_req || w_force_dma);
    assign w_core_win = core_req && !w_dma_win;
    assign core_ready = !reset && w_core_win;
    assign dma_ready  = !reset && w_dma_win;
    assign w_xfer     = core_ready || dma_ready;

    always_comb begin
        w_sel = '0;
        if (dma_ready) begin
            w_sel = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
        end else if (core_ready) begin
            w_sel = '{we: core_we, addr: core_addr, wdata: core_wdata};
        end
    end

    // Out-of-range accesses still complete on the port but never reach the RAM.
    assign w_oor     = w_xfer && ({1'b0, w_sel.addr} >= (ADDRWIDTH + 1)'(RAMDEPTH));
    assign ram_en    = w_xfer && !w_oor;
    assign ram_we    = ram_en && w_sel.we;
    assign ram_addr  = w_sel.addr;
    assign ram_wdata = w_sel.wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_owner <= OWN_NONE;
            r_pend_oor   <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_pend_oor <= w_oor;
            if (w_xfer && !w_sel.we) begin
                r_pend_owner <= dma_ready ? OWN_DMA : OWN_CORE;
            end else begin
                r_pend_owner <= OWN_NONE;
            end
            if (w_oor) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign addr_err    = r_addr_err;
    assign core_rvalid = (r_pend_owner == OWN_CORE);
    assign dma_rvalid  = (r_pend_owner == OWN_DMA);
    assign core_rdata  = (core_rvalid && !r_pend_oor) ? ram_rdata : '0;
    assign dma_rdata   = (dma_rvalid && !r_pend_oor) ? ram_rdata : '0;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Directed bench for dataram_arbiter with a behavioural 1024-word RAM behind it.
module tb_dataram_arbiter;

    logic        clock;
    logic        reset;
    logic        core_req, core_we;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ready, core_rvalid;
    logic [31:0] core_rdata;
    logic        dma_req, dma_we;
    logic [11:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ready, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        addr_err;

    logic [31:0] mem [0:1023];
    int          n_total = 0;
    int          n_bad   = 0;

    dataram_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_ready  (core_ready),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ready   (dma_ready),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .addr_err    (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[9:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic dma_drive(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        reset = 1'b1;
        dma_drive(1'b0, 1'b0, 12'd0, 32'd0);
        core_drive(1'b1, 1'b1, 12'd5, 32'h1234);

        // Reset held two cycles with the core requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_core_ready", core_ready, 0);
            check_eq("rst_ram_en", ram_en, 0);
            check_eq("rst_core_rvalid", core_rvalid, 0);
            check_eq("rst_dma_rvalid", dma_rvalid, 0);
            check_eq("rst_addr_err", addr_err, 0);
        end
        reset = 1'b0;
        #1;
        check_eq("rel_core_ready", core_ready, 1);
        check_eq("wr_ram_en", ram_en, 1);
        check_eq("wr_ram_we", ram_we, 1);
        check_eq("wr_ram_addr", ram_addr, 5);
        check_eq("wr_ram_wdata", ram_wdata, 32'h1234);
        tick();

        // Core read of addr 5, one cycle latency
        core_drive(1'b1, 1'b0, 12'd5, 32'd0);
        #1;
        check_eq("wr_no_rvalid", core_rvalid, 0);
        check_eq("rd_ram_en", ram_en, 1);
        check_eq("rd_ram_we", ram_we, 0);
        check_eq("rd_ram_addr", ram_addr, 5);
        tick();
        core_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("rd_core_rvalid", core_rvalid, 1);
        check_eq("rd_core_rdata", core_rdata, 32'h1234);
        check_eq("rd_dma_rvalid", dma_rvalid, 0);
        check_eq("idle_ram_en", ram_en, 0);
        check_eq("idle_ram_addr", ram_addr, 0);
        tick();

        // Starvation: both ports requesting for 20 cycles
        core_drive(1'b1, 1'b0, 12'd10, 32'd0);
        dma_drive(1'b1, 1'b0, 12'd20, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            #1;
            check_eq($sformatf("starve_dma_ready_c%0d", i), dma_ready, (i % 5 == 0) ? 1 : 0);
            check_eq($sformatf("starve_core_ready_c%0d", i), core_ready, (i % 5 == 0) ? 0 : 1);
            tick();
        end
        core_drive(1'b0, 1'b0, 12'd0, 32'd0);
        dma_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("starve_last_dma_rvalid", dma_rvalid, 1);
        tick();

        // Preload mem[1], mem[2] through the core port
        core_drive(1'b1, 1'b1, 12'd1, 32'h0000_00A1);
        tick();
        core_drive(1'b1, 1'b1, 12'd2, 32'h0000_00B2);
        tick();

        // Alternating owners: core read then DMA read
        core_drive(1'b1, 1'b0, 12'd1, 32'd0);
        tick();
        core_drive(1'b0, 1'b0, 12'd0, 32'd0);
        dma_drive(1'b1, 1'b0, 12'd2, 32'd0);
        #1;
        check_eq("alt_dma_ready", dma_ready, 1);
        check_eq("alt_core_rvalid", core_rvalid, 1);
        check_eq("alt_core_rdata", core_rdata, 32'hA1);
        check_eq("alt_dma_rvalid_t1", dma_rvalid, 0);
        check_eq("alt_dma_rdata_t1", dma_rdata, 0);
        tick();
        dma_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("alt_dma_rvalid", dma_rvalid, 1);
        check_eq("alt_dma_rdata", dma_rdata, 32'hB2);
        check_eq("alt_core_rvalid_t2", core_rvalid, 0);
        check_eq("alt_core_rdata_t2", core_rdata, 0);
        tick();

        // Out of range DMA write then read at 1024
        dma_drive(1'b1, 1'b1, 12'd1024, 32'hDEAD);
        #1;
        check_eq("oor_wr_ready", dma_ready, 1);
        check_eq("oor_wr_ram_en", ram_en, 0);
        check_eq("oor_err_before", addr_err, 0);
        tick();
        check_eq("oor_err_set", addr_err, 1);
        check_eq("oor_wr_no_rvalid", dma_rvalid, 0);
        dma_drive(1'b1, 1'b0, 12'd1024, 32'd0);
        #1;
        check_eq("oor_rd_ready", dma_ready, 1);
        check_eq("oor_rd_ram_en", ram_en, 0);
        tick();
        dma_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("oor_rd_rvalid", dma_rvalid, 1);
        check_eq("oor_rd_rdata", dma_rdata, 0);
        check_eq("oor_mem0_intact", mem[0], 0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("oor_err_sticky", addr_err, 1);

        // In-range read after the error still works, flag stays
        core_drive(1'b1, 1'b0, 12'd1, 32'd0);
        tick();
        core_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("post_oor_rdata", core_rdata, 32'hA1);
        check_eq("post_oor_err", addr_err, 1);

        // Reset rising with a core read presented
        reset = 1'b1;
        core_drive(1'b1, 1'b0, 12'd1, 32'd0);
        #1;
        check_eq("rr_core_ready", core_ready, 0);
        check_eq("rr_ram_en", ram_en, 0);
        tick();
        reset = 1'b0;
        core_drive(1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        check_eq("rr_core_rvalid", core_rvalid, 0);
        check_eq("rr_core_rdata", core_rdata, 0);
        check_eq("rr_err_cleared", addr_err, 0);
        tick();
        check_eq("rr_core_rvalid_after", core_rvalid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dataram_arbiter.md
Name: dataram_arbiter

Overview:
- Shares the single-port, word-addressed data RAM of riscv32s between two requesters: the core load/store port and a DMA/readout port. The DMA port is used by the JPEG output streamer and by the end-of-run memory dump.
- Issues at most one RAM access per cycle.
- Core has default priority; a starvation counter guarantees the DMA port a slot.
- Routes the 1-cycle-latency read data back to the issuing requester.
- Flags out-of-range addresses.

Parameters:
- ADDRWIDTH, 12, word-address width of both request ports.
- DATAWIDTH, 32, data width.
- RAMDEPTH, 1024, number of implemented RAM words; addresses >= RAMDEPTH are out of range.
- MAXWAIT, 4, number of consecutive denied DMA cycles before the DMA port is forced a grant.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDRWIDTH  core word address.
- core_wdata  in  DATAWIDTH  core write data.
- core_ready  out  1  core request accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATAWIDTH  core read data.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDRWIDTH/DATAWIDTH  same as core.
- dma_ready, dma_rvalid  out  1  same as core.
- dma_rdata  out  DATAWIDTH  same as core.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDRWIDTH  RAM word address.
- ram_wdata  out  DATAWIDTH  RAM write data.
- ram_rdata  in  DATAWIDTH  RAM read data, valid the cycle after a read strobe.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (synchronous, any cycle, including with a read in flight):
  - Clears the pending-read owner to OWN_NONE, the wait counter to 0, and addr_err to 0.
  - While reset is high: core_ready = dma_ready = 0, ram_en = 0.
  - The cycle after reset: core_rvalid = dma_rvalid = 0. A read issued in the same cycle reset rises is discarded, with no rvalid.
- Grant decision (combinational, each cycle):
  - force_dma = dma_req && (waitcnt == MAXWAIT).
  - DMA wins if dma_req && (!core_req || force_dma); otherwise core wins if core_req.
  - The winner's ready = 1; the loser's ready = 0.
  - A request is transferred when req && ready. Requesters hold all request fields stable until ready.
- Wait counter:
  - Next = 0 if !dma_req or the DMA is granted.
  - Otherwise next = min(waitcnt + 1, MAXWAIT).
  - With both ports requesting continuously, the DMA is granted exactly once every MAXWAIT+1 cycles.
- RAM drive (combinational):
  - For an in-range transfer: ram_en = 1, and ram_we/addr/wdata come from the winner.
  - With no transfer: ram_en = 0, and ram_addr/ram_wdata = 0.
- Out-of-range transfer (addr >= RAMDEPTH):
  - ready is still 1 (the transfer completes), but ram_en = 0.
  - A write is dropped.
  - A read still produces rvalid next cycle with rdata = 0.
  - addr_err is set to 1 on the next edge and stays set until reset.
- Read return (registered owner):
  - On a read transfer, the pending register <= {OWN_CORE | OWN_DMA, oor bit}; otherwise it is OWN_NONE.
  - Next cycle: the owner's rvalid = 1 for exactly one cycle.
  - The owner's rdata = ram_rdata, or 0 if oor. The non-owner's rdata = 0.
  - Read latency is 1 cycle from the transfer edge.
  - Back-to-back reads from alternating owners are supported every cycle.
- Writes produce no rvalid.
- Simultaneous read return and new request: independent. The return path never stalls issue.

Decomposition:
- Package dataram_arbiter_pkg holds:
  - owner_t enum {OWN_NONE, OWN_CORE, OWN_DMA}.
  - A request struct {we, addr, wdata}.
- Sub-module arb_starve_counter (param MAXWAIT):
  - Inputs: dma_req, dma_grant.
  - Output: force_dma.
  - Contains the saturating counter.
- Top-level contains the grant logic, RAM mux, pending-owner register and addr_err.

Test Plan:
- Reset: assert reset 2 cycles with core_req=1 -> core_ready=0, ram_en=0, both rvalid=0, addr_err=0. Then deassert -> core_ready=1 the same cycle.
- Core read latency: write core mem[5]=0x1234 and RAM responds; next, core read addr 5 -> ram_en=1, ram_we=0, ram_addr=5. Next cycle core_rvalid=1, core_rdata=0x1234, dma_rvalid=0.
- Starvation, MAXWAIT=4, core_req and dma_req held high 20 cycles -> dma_ready high on cycles 5, 10, 15, 20 only; core_ready high on all other cycles.
- Alternating owners: core read addr 1 at t, DMA read addr 2 at t+1 (core_req low) -> core_rvalid at t+1 with mem[1], dma_rvalid at t+2 with mem[2], no overlap.
- Out of range: DMA write addr 1024 data 0xDEAD, then DMA read addr 1024 -> ram_en=0 both cycles; the read gives dma_rvalid=1 with dma_rdata=0; addr_err=1 and stays set until reset.
- Reset mid-read: core read issued in the cycle reset goes high -> core_rvalid=0 the next cycle and the pending owner is OWN_NONE.
